// File: rtl/mmio_timer_if.sv
// Bus interface of the MMIO timer: request, write data, read data and completion pulse.
// The master drives requests; the slave (the timer) returns read data and the ack.
interface mmio_timer_if;
  logic        rd_en_i;
  logic        wr_en_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (
    output rd_en_i,
    output wr_en_i,
    output addr_i,
    output data_i,
    input  data_o,
    input  ack_o
  );

  modport slave (
    input  rd_en_i,
    input  wr_en_i,
    input  addr_i,
    input  data_i,
    output data_o,
    output ack_o
  );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit up-counter with compare match, optional auto-reload
// and a level interrupt, exposed through a 16-byte register window.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic         clk,
  input  logic         rst,
  mmio_timer_if.slave  bus,
  output logic         irq_o
);

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_COUNT   = 2'd1,
    REG_COMPARE = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_t;

  logic [2:0]  ctrl_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        status_q;
  logic [31:0] data_q;
  logic        ack_q;

  logic        in_window;
  logic        accept;
  logic        do_write;
  logic        do_read;
  reg_sel_t    sel;
  logic        match;
  logic [31:0] read_value;

  assign in_window = (bus.addr_i[31:4] == BASE_ADDR[31:4]);
  assign accept    = in_window && (bus.rd_en_i || bus.wr_en_i);
  // A simultaneous read and write is treated as a write only.
  assign do_write  = accept && bus.wr_en_i;
  assign do_read   = accept && bus.rd_en_i && !bus.wr_en_i;
  assign sel       = reg_sel_t'(bus.addr_i[3:2]);
  assign match     = ctrl_q[0] && (count_q == compare_q);

  always_comb begin
    read_value = 32'd0;
    case (sel)
      REG_CTRL:    read_value = {29'd0, ctrl_q};
      REG_COUNT:   read_value = count_q;
      REG_COMPARE: read_value = compare_q;
      REG_STATUS:  read_value = {31'd0, status_q};
      default:     read_value = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= 3'd0;
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      status_q  <= 1'b0;
      data_q    <= 32'd0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= accept;

      if (do_read) begin
        data_q <= read_value;
      end

      if (do_write && sel == REG_CTRL) begin
        ctrl_q <= bus.data_i[2:0];
      end

      if (do_write && sel == REG_COMPARE) begin
        compare_q <= bus.data_i;
      end

      // Bus write to COUNT overrides the counter's own update in the same cycle.
      if (do_write && sel == REG_COUNT) begin
        count_q <= bus.data_i;
      end else if (ctrl_q[0]) begin
        if (match && ctrl_q[1]) begin
          count_q <= 32'd0;
        end else begin
          count_q <= count_q + 32'd1;
        end
      end

      // A hardware match beats a same-cycle write-1-to-clear.
      if (match) begin
        status_q <= 1'b1;
      end else if (do_write && sel == REG_STATUS && bus.data_i[0]) begin
        status_q <= 1'b0;
      end
    end
  end

  // The pending ack is suppressed as soon as reset is asserted.
  assign bus.ack_o  = ack_q && !rst;
  assign bus.data_o = data_q;
  assign irq_o      = status_q && ctrl_q[2];

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_2000, base byte address of the 16-byte register window.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: rd_en_i  input  1  read request, sampled each rising edge.
REQ-005 Port: wr_en_i  input  1  write request, sampled each rising edge.
REQ-006 Port: addr_i  input  32  byte address; bits [3:2] select the register; bits [1:0] are ignored.
REQ-007 Port: data_i  input  32  write data.
REQ-008 Port: data_o  output  32  read data; holds the last read value until the next accepted read.
REQ-009 Port: ack_o  output  1  one-cycle completion pulse for an accepted request.
REQ-010 Port: irq_o  output  1  level interrupt, STATUS[0] AND CTRL[2].

Function
REQ-011 A request shall be accepted only when addr_i[31:4] == BASE_ADDR[31:4] and rd_en_i or wr_en_i is high at a rising edge.
REQ-012 Requests outside the window shall be ignored: no ack_o, no state change, data_o unchanged.
REQ-013 Register map (offset, access):
- 0x0 CTRL (RW): bit0 enable, bit1 auto-reload, bit2 irq enable; bits [31:3] read 0.
- 0x4 COUNT (RW).
- 0x8 COMPARE (RW).
- 0xC STATUS (bit0 match flag): write-1-to-clear; bits [31:1] read 0.
REQ-014 ack_o shall go high for exactly one cycle, in the cycle after acceptance; back-to-back accepted requests shall give back-to-back acks.
REQ-015 On an accepted read, data_o shall be loaded at the accepting edge with the register value before that edge's updates; it shall be valid while ack_o is high.
REQ-016 If rd_en_i and wr_en_i are both high at acceptance, the write shall be performed and the read dropped: a single ack, data_o unchanged.
REQ-017 When CTRL[0]=1 and COUNT != COMPARE, COUNT shall increment by 1 per cycle, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-018 When CTRL[0]=1 and COUNT == COMPARE:
- STATUS[0] shall be set.
- COUNT shall load 0 if CTRL[1]=1; otherwise it shall increment (with wrap).
REQ-019 When CTRL[0]=0, COUNT shall hold and no match shall be detected.
REQ-020 A bus write to COUNT shall override the increment/reload of the same cycle.
REQ-021 A hardware set of STATUS[0] shall win over a same-cycle W1C.
REQ-022 Writing 0 to STATUS[0] shall have no effect.
REQ-023 A CTRL write shall take effect from the following cycle; the counter behaviour in the write cycle uses the old CTRL.
REQ-024 irq_o shall be driven combinationally from registered state only: no path from bus inputs.

Reset
REQ-025 While rst=1, the following shall hold at each rising edge:
- CTRL=0, COUNT=0, STATUS=0, COMPARE=0xFFFFFFFF.
- data_o=0, ack_o=0, irq_o=0.
REQ-026 A request accepted in the cycle before rst asserts shall not produce ack_o.
REQ-027 Requests presented while rst=1 shall be discarded.

Verification
REQ-028 Reset read-back -> after rst, read 0x0 / 0x8 / 0xC -> data_o 0 / 0xFFFFFFFF / 0; each ack_o pulse exactly 1 cycle after rd_en_i.
REQ-029 Auto-reload match -> write COMPARE=5, COUNT=0, then CTRL=0x7 -> COUNT runs 0..5, STATUS[0]=1 and irq_o=1 one cycle after COUNT==5, COUNT=0 on that same cycle.
REQ-030 W1C -> with STATUS[0]=1:
- write STATUS=0 -> irq_o stays 1.
- write STATUS=1 with CTRL[0]=0 -> STATUS[0]=0 and irq_o=0 the cycle after the write.
REQ-031 Wrap without reload -> CTRL=0x1, COMPARE=3, COUNT=0xFFFFFFFE -> sequence FFFFFFFE, FFFFFFFF, 0, 1, 2, 3, 4; STATUS[0] set after 3; irq_o stays 0.
REQ-032 Address decode -> read at BASE_ADDR+0x10 -> no ack_o within 4 cycles, data_o unchanged; read at BASE_ADDR+0x6 -> returns COUNT.
REQ-033 Collision -> rd_en_i=wr_en_i=1 to 0x4 with data_i=0x100 while counting -> single ack, COUNT=0x100 next cycle, data_o unchanged.
